// File: rtl/agent_handover_link_if.sv
// Valid/ready handshake bundle between the sending agent (alice) and the receiving agent (bob).
// master = the token producer/consumer side; slave = the link itself.
interface agent_handover_link_if #(
    parameter int DATA_W = 8
);
    logic              send_valid;
    logic [DATA_W-1:0] send_data;
    logic              send_ready;
    logic              recv_valid;
    logic [DATA_W-1:0] recv_data;
    logic              recv_ready;

    modport master (
        output send_valid, send_data, recv_ready,
        input  send_ready, recv_valid, recv_data
    );

    modport slave (
        input  send_valid, send_data, recv_ready,
        output send_ready, recv_valid, recv_data
    );
endinterface

// File: rtl/agent_handover_link.sv
// Purpose: FWFT token buffer from alice to bob with independent sent/delivered counters.
// Latency: one cycle from push to recv_valid/recv_data.
// Backpressure: send_ready=0 while full, decoded from registered occupancy only.
module agent_handover_link #(
    parameter int CNT_W    = 8,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    agent_handover_link_if.slave     lnk,
    input  logic                     count_clear,
    output logic [CNT_W-1:0]         alice_count,
    output logic [CNT_W-1:0]         bob_count,
    output logic [$clog2(DEPTH):0]   in_flight,
    output logic                     cnt_sat
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [CNT_W-1:0]  alice_q, alice_d;
    logic [CNT_W-1:0]  bob_q, bob_d;
    logic              sat_q, sat_d;
    logic              push, pop;
    logic              a_hit, b_hit;

    // Returns {event, next}: event is a wrap (wrap mode) or reaching all-ones (saturate mode).
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] c, input logic en);
        logic [CNT_W-1:0] nxt;
        bump = {1'b0, c};
        nxt  = c + CNT_W'(1);
        if (en) begin
            if (c == {CNT_W{1'b1}}) begin
                if (SATURATE == 0) bump = {1'b1, {CNT_W{1'b0}}};
            end else begin
                bump = {(SATURATE != 0) && (nxt == {CNT_W{1'b1}}), nxt};
            end
        end
    endfunction

    assign lnk.send_ready = (occ_q != OW'(DEPTH));
    assign lnk.recv_valid = (occ_q != '0);
    assign lnk.recv_data  = mem_q[rd_ptr_q];

    assign push = lnk.send_valid & lnk.send_ready;
    assign pop  = lnk.recv_valid & lnk.recv_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = lnk.send_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        {a_hit, alice_d} = bump(alice_q, push);
        {b_hit, bob_d}   = bump(bob_q, pop);
        sat_d            = sat_q | a_hit | b_hit;
        // Transfers in a clearing cycle still move data but are deliberately not counted.
        if (count_clear) begin
            alice_d = '0;
            bob_d   = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            alice_q  <= '0;
            bob_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            alice_q  <= alice_d;
            bob_q    <= bob_d;
            sat_q    <= sat_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign alice_count = alice_q;
    assign bob_count   = bob_q;
    assign in_flight   = occ_q;
    assign cnt_sat     = sat_q;
endmodule

// File: doc/agent_handover_link.md
Name: agent_handover_link

Overview:
- Parametrised successor to the single-counter agent pair.
- A sending agent (alice) hands tokens to a receiving agent (bob) through a DEPTH-entry first-word-fall-through buffer, using valid/ready handshakes on both sides.
- Each side keeps its own CNT_W-bit handover counter, with a wrap or saturate mode selected at build time.
- Sits between any token producer and consumer in the agent fabric; gives true backpressure and an independent count of tokens sent and tokens delivered.

Parameters:
- CNT_W, 8, width of alice_count / bob_count (>=2).
- DATA_W, 8, token payload width (>=1).
- DEPTH, 4, buffer entries; power of two, >=2.
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters hold at all-ones.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- send_valid  in  1  alice offers a token.
- send_data  in  DATA_W  token payload.
- send_ready  out  1  link can accept; equals !full.
- recv_valid  out  1  token available to bob; equals !empty.
- recv_data  out  DATA_W  payload at buffer head.
- recv_ready  in  1  bob consumes the head token.
- count_clear  in  1  synchronous clear of counters and sticky flags only.
- alice_count  out  CNT_W  tokens accepted (send handshakes).
- bob_count  out  CNT_W  tokens delivered (recv handshakes).
- in_flight  out  $clog2(DEPTH)+1  current buffer occupancy.
- cnt_sat  out  1  sticky; a counter hit all-ones in SATURATE=1 or wrapped in SATURATE=0.

Behaviour:
- Reset (rst=1 at edge):
  - buffer empty; in_flight=0, alice_count=0, bob_count=0, cnt_sat=0.
  - Outputs after reset: send_ready=1, recv_valid=0.
  - recv_data is don't-care while recv_valid=0.
  - rst has priority over every other input, including mid-transfer; buffered tokens are discarded.
- push = send_valid & send_ready; pop = recv_valid & recv_ready. Both are evaluated on pre-edge state.
- send_ready and recv_valid are decoded from registered occupancy only. No combinational path from send_valid or recv_ready to either.
- Latency: a token pushed at edge k gives recv_valid=1 with its payload on recv_data from just after edge k (one cycle).
- Ordering is strict FIFO. recv_data holds stable while recv_valid=1 and no pop occurs.
- Full (in_flight=DEPTH): send_ready=0. No push, even if pop happens the same cycle; send_ready returns 1 the cycle after the pop.
- Empty: recv_valid=0; recv_ready is ignored.
- Simultaneous push and pop (0<in_flight<DEPTH): in_flight unchanged; both counters increment.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter.
- alice_count increments on push, bob_count on pop, each by 1 per cycle max.
- SATURATE=0: all-ones+1 wraps to 0 and sets cnt_sat.
- SATURATE=1: all-ones holds; cnt_sat is set on the edge where a counter becomes all-ones.
- count_clear=1 at edge:
  - alice_count=0, bob_count=0, cnt_sat=0.
  - A push or pop in the same cycle is still transferred but not counted.
  - Buffer contents and in_flight are unaffected.
- Invariant, wrap mode with no clears since reset: (alice_count - bob_count) mod 2^CNT_W == in_flight.

Test Plan:
- Reset, then idle 3 cycles -> send_ready=1, recv_valid=0, in_flight=0, both counts 0.
- DEPTH=4, recv_ready=0, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> first four accepted, send_ready=0 from cycle 4, 0x55 held off, alice_count=4, in_flight=4; then recv_ready=1 -> drains 0x11..0x44 in order, 0x55 accepted the cycle after first pop.
- Continuous send_valid=1, recv_ready=1 for 20 cycles at in_flight=1 -> one token per cycle, in_flight stays 1, alice_count=20, bob_count=19 after the last edge.
- CNT_W=4, SATURATE=0, 17 push/pop pairs -> counts wrap 15->0, cnt_sat=1 after the 16th, final counts 1.
- CNT_W=4, SATURATE=1, 20 pushes with draining -> counts stop at 15, cnt_sat=1; then count_clear -> counts 0, cnt_sat=0, in_flight unchanged.
- Fill to 3 tokens, assert rst with send_valid=1 and recv_ready=1 -> next cycle all zero, recv_valid=0, none of the 3 tokens ever appear on recv_data.
